dat_mem_p: RTL and testbench

Parametrised successor to the 8x256 data memory: DW-bit wide, 2**AW-deep, one write port and one registered read port with separate addresses. After every reset a built-in clear engine zeroes words CLR_LO..DEPTH-1, one word per cycle, and reports busy while it runs. Reads have one-cycle latency with a valid strobe and write-first forwarding. It replaces the fixed data memory on the datapath's load/store port.

---
 rtl/dat_mem_p.sv | 148 ++++++++++++++
 tb/tb_dat_mem_p.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dat_mem_p.sv
`default_nettype none
// ============================================================================
// Module   : dat_mem_p
// Summary  : Parametrised single-clock data memory with one write port, one
//            registered read port (1-cycle latency, valid strobe, write-first
//            forwarding) and a post-reset clear engine that zeroes words
//            CLR_LO..DEPTH-1, one word per cycle, while reporting busy.
// Revision : 1.0 - initial release
// ============================================================================
module dat_mem_p #(
    parameter int DW     = 8,
    parameter int AW     = 8,
    parameter int CLR_LO = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] dat_in,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] dat_out,
    output logic          rd_valid,
    output logic          busy,
    output logic          acc_err
);

    // Geometry and clear-range constants
    localparam int            c_DEPTH     = 2**AW;
    localparam logic [AW-1:0] c_CLR_FIRST = AW'(CLR_LO);
    localparam logic [AW-1:0] c_CLR_LAST  = {AW{1'b1}};
    localparam logic [AW-1:0] c_PTR_ONE   = AW'(1);

    // State encoding
    localparam logic [0:0] c_ST_CLEAR = 1'b0;
    localparam logic [0:0] c_ST_READY = 1'b1;

    // Storage array; never reset so words below CLR_LO survive a reset
    logic [DW-1:0] r_mem [c_DEPTH];

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic [AW-1:0] r_clr_ptr;
    logic          w_clr_last;
    logic          w_busy;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic          w_fwd;
    logic [DW-1:0] r_dat_out;
    logic          r_rd_valid;
    logic          r_acc_err;

    // The pointer is compared before it increments, so CLR_LO = DEPTH-1
    // finishes in one cycle without the pointer ever needing to wrap
    assign w_clr_last = (r_clr_ptr == c_CLR_LAST);

    // Requests only take effect once the clear engine has finished
    assign w_wr_acc = wr_en & ~w_busy;
    assign w_rd_acc = rd_en & ~w_busy;
    assign w_fwd    = w_wr_acc & (wr_addr == rd_addr);

    // State register: every reset (including one mid-clear) restarts CLEAR
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: leave CLEAR on the cycle the top word is written
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_CLEAR: begin
                if (w_clr_last) begin
                    w_state_nxt = c_ST_READY;
                end
            end
            c_ST_READY: begin
                w_state_nxt = c_ST_READY;
            end
            default: begin
                w_state_nxt = c_ST_CLEAR;
            end
        endcase
    end

    // Output decode: busy comes straight from the state, no delay
    always_comb begin
        w_busy = 1'b1;
        case (r_state)
            c_ST_CLEAR: w_busy = 1'b1;
            c_ST_READY: w_busy = 1'b0;
            default:    w_busy = 1'b1;
        endcase
    end

    // Clear pointer: reload on reset, advance once per clear cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clr_ptr <= c_CLR_FIRST;
        end else if (w_busy && !w_clr_last) begin
            r_clr_ptr <= r_clr_ptr + c_PTR_ONE;
        end
    end

    // Array write port, shared between the clear engine and user writes;
    // the reset cycle itself leaves the array untouched
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_busy) begin
                r_mem[r_clr_ptr] <= '0;
            end else if (wr_en) begin
                r_mem[wr_addr] <= dat_in;
            end
        end
    end

    // Registered read port with write-first forwarding; data holds when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dat_out  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_dat_out <= w_fwd ? dat_in : r_mem[rd_addr];
            end
        end
    end

    // Sticky flag for any request presented while the clear engine runs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc_err <= 1'b0;
        end else if (w_busy && (wr_en || rd_en)) begin
            r_acc_err <= 1'b1;
        end
    end

    assign dat_out  = r_dat_out;
    assign rd_valid = r_rd_valid;
    assign busy     = w_busy;
    assign acc_err  = r_acc_err;

endmodule
`default_nettype wire

// File: tb/tb_dat_mem_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_dat_mem_p
// Summary  : Self-checking bench for dat_mem_p. Two instances (CLR_LO = 0 and
//            CLR_LO = 60) are driven by directed steps followed by random
//            traffic and compared every cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dat_mem_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Index 0: default instance, index 1: CLR_LO = 60 instance
    logic [1:0]      rst_v;
    logic [1:0]      we_v;
    logic [1:0]      re_v;
    logic [1:0][7:0] wa_v;
    logic [1:0][7:0] din_v;
    logic [1:0][7:0] ra_v;
    wire  [1:0][7:0] dout_v;
    wire  [1:0]      vld_v;
    wire  [1:0]      bsy_v;
    wire  [1:0]      err_v;

    dat_mem_p #(.DW(8), .AW(8), .CLR_LO(0)) u_dut_a (
        .clk(clk), .reset(rst_v[0]),
        .wr_en(we_v[0]), .wr_addr(wa_v[0]), .dat_in(din_v[0]),
        .rd_en(re_v[0]), .rd_addr(ra_v[0]),
        .dat_out(dout_v[0]), .rd_valid(vld_v[0]), .busy(bsy_v[0]), .acc_err(err_v[0])
    );

    dat_mem_p #(.DW(8), .AW(8), .CLR_LO(60)) u_dut_b (
        .clk(clk), .reset(rst_v[1]),
        .wr_en(we_v[1]), .wr_addr(wa_v[1]), .dat_in(din_v[1]),
        .rd_en(re_v[1]), .rd_addr(ra_v[1]),
        .dat_out(dout_v[1]), .rd_valid(vld_v[1]), .busy(bsy_v[1]), .acc_err(err_v[1])
    );

    // Behavioural model state
    int         clr_lo [2] = '{0, 60};
    logic [7:0] m_mem   [2][256];
    bit         m_known [2][256];
    int         m_left  [2];
    logic [7:0] e_dout  [2];
    bit         e_dk    [2];
    bit         e_vld   [2];
    bit         e_err   [2];

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // Model of one clock edge: a reset schedules a clear of the upper range,
    // which completes (invisibly, since requests are refused) before READY
    task automatic model_step(input int k);
        if (rst_v[k]) begin
            m_left[k] = 256 - clr_lo[k];
            e_dout[k] = 8'h00;
            e_dk[k]   = 1'b1;
            e_vld[k]  = 1'b0;
            e_err[k]  = 1'b0;
            for (int a = clr_lo[k]; a < 256; a++) begin
                m_mem[k][a]   = 8'h00;
                m_known[k][a] = 1'b1;
            end
        end else if (m_left[k] > 0) begin
            if (we_v[k] || re_v[k]) e_err[k] = 1'b1;
            e_vld[k] = 1'b0;
            m_left[k]--;
        end else begin
            if (re_v[k]) begin
                e_vld[k] = 1'b1;
                if (we_v[k] && wa_v[k] == ra_v[k]) begin
                    e_dout[k] = din_v[k];
                    e_dk[k]   = 1'b1;
                end else begin
                    e_dout[k] = m_mem[k][ra_v[k]];
                    e_dk[k]   = m_known[k][ra_v[k]];
                end
            end else begin
                e_vld[k] = 1'b0;
            end
            if (we_v[k]) begin
                m_mem[k][wa_v[k]]   = din_v[k];
                m_known[k][wa_v[k]] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk("busy", k, bsy_v[k], m_left[k] > 0);
            chk("rd_valid", k, vld_v[k], e_vld[k]);
            chk("acc_err", k, err_v[k], e_err[k]);
            if (e_dk[k]) chk("dat_out", k, dout_v[k], e_dout[k]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all();
    endtask

    task automatic idle();
        rst_v = '0; we_v = '0; re_v = '0;
    endtask

    task automatic set_wr(input int k, input logic [7:0] a, input logic [7:0] d);
        we_v[k] = 1'b1; wa_v[k] = a; din_v[k] = d;
    endtask

    task automatic set_rd(input int k, input logic [7:0] a);
        re_v[k] = 1'b1; ra_v[k] = a;
    endtask

    int cnt_a;
    int cnt_b;

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_left[k] = 0; e_dout[k] = 8'h00; e_dk[k] = 1'b0;
            e_vld[k] = 1'b0; e_err[k] = 1'b0;
            for (int a = 0; a < 256; a++) m_known[k][a] = 1'b0;
        end
        idle();
        wa_v = '0; din_v = '0; ra_v = '0;

        // Reset both instances
        rst_v = 2'b11;
        tick();
        tick();
        chk("reset_busy", 0, bsy_v[0], 1'b1);
        chk("reset_dout", 0, dout_v[0], 8'h00);
        idle();

        // Clear duration: 256 cycles (CLR_LO=0) and 196 cycles (CLR_LO=60)
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 300 && bsy_v != 2'b00; i++) begin
            cnt_a += int'(bsy_v[0]);
            cnt_b += int'(bsy_v[1]);
            tick();
        end
        chk("clear_len_a", 0, cnt_a, 256);
        chk("clear_len_b", 1, cnt_b, 196);

        // Cleared words read back zero with a single valid pulse
        foreach (ra_v[0][j]) begin end
        for (int j = 0; j < 3; j++) begin
            set_rd(0, (j == 0) ? 8'd0 : (j == 1) ? 8'd128 : 8'd255);
            tick();
            chk("clr_rd_data", 0, dout_v[0], 8'h00);
            chk("clr_rd_vld", 0, vld_v[0], 1'b1);
            idle();
            tick();
            chk("clr_rd_pulse", 0, vld_v[0], 1'b0);
        end

        // Write then read, data holds after the read
        set_wr(0, 8'h3C, 8'hA5);
        tick();
        idle();
        set_rd(0, 8'h3C);
        tick();
        chk("wr_rd_data", 0, dout_v[0], 8'hA5);
        chk("wr_rd_vld", 0, vld_v[0], 1'b1);
        idle();
        tick();
        chk("hold_vld", 0, vld_v[0], 1'b0);
        chk("hold_data", 0, dout_v[0], 8'hA5);

        // Write-first forwarding on a same-address collision
        set_wr(0, 8'h10, 8'h11);
        tick();
        idle();
        set_wr(0, 8'h10, 8'h7E);
        set_rd(0, 8'h10);
        tick();
        chk("fwd_data", 0, dout_v[0], 8'h7E);
        idle();
        set_rd(0, 8'h10);
        tick();
        chk("fwd_after", 0, dout_v[0], 8'h7E);
        idle();

        // Streaming reads of 0..7 after writing i*3
        for (int i = 0; i < 8; i++) begin
            set_wr(0, 8'(i), 8'(i * 3));
            tick();
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            set_rd(0, 8'(i));
            tick();
            chk("stream_vld", 0, vld_v[0], 1'b1);
            chk("stream_data", 0, dout_v[0], 8'(i * 3));
        end
        idle();
        tick();
        chk("stream_end", 0, vld_v[0], 1'b0);

        // CLR_LO=60: low words survive reset, upper words are cleared
        set_wr(1, 8'd10, 8'h55);
        tick();
        idle();
        set_wr(1, 8'd100, 8'h66);
        tick();
        idle();
        rst_v[1] = 1'b1;
        tick();
        idle();
        cnt_b = 0;
        for (int i = 0; i < 300 && bsy_v[1]; i++) begin
            cnt_b++;
            tick();
        end
        chk("partial_len", 1, cnt_b, 196);
        set_rd(1, 8'd10);
        tick();
        chk("keep_low", 1, dout_v[1], 8'h55);
        idle();
        set_rd(1, 8'd100);
        tick();
        chk("clear_high", 1, dout_v[1], 8'h00);
        idle();

        // Request during clear sets acc_err; reset mid-clear restarts it
        set_wr(0, 8'd5, 8'h2B);
        tick();
        idle();
        rst_v[0] = 1'b1;
        tick();
        idle();
        set_wr(0, 8'd5, 8'hFF);
        tick();
        idle();
        repeat (49) tick();
        chk("err_set", 0, err_v[0], 1'b1);
        chk("busy_mid", 0, bsy_v[0], 1'b1);
        rst_v[0] = 1'b1;
        tick();
        idle();
        chk("err_clr", 0, err_v[0], 1'b0);
        cnt_a = 0;
        for (int i = 0; i < 300 && bsy_v[0]; i++) begin
            cnt_a++;
            tick();
        end
        chk("restart_len", 0, cnt_a, 256);
        set_rd(0, 8'd5);
        tick();
        chk("ignored_wr", 0, dout_v[0], 8'h00);
        idle();

        // Random traffic on both instances against the model
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < 2; k++) begin
                rst_v[k] = ($urandom_range(0, 399) == 0);
                we_v[k]  = 1'($urandom_range(0, 1));
                re_v[k]  = 1'($urandom_range(0, 1));
                wa_v[k]  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
                ra_v[k]  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
                din_v[k] = 8'($urandom);
            end
            tick();
        end
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
